// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: ALU/LSU result handshakes, issue scoreboard port and
// register-file write port.
interface writeback_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_we;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_valid, issue_rd,
    input  alu_ready, lsu_ready, busy, rd_addr, rd_data, rd_we
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_valid, issue_rd,
    output alu_ready, lsu_ready, busy, rd_addr, rd_data, rd_we
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU results and queued LSU results onto one register-file write
// port, with starvation protection for the LSU queue and a pending-write scoreboard.
module writeback_arbiter #(
    parameter int LSU_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    writeback_arbiter_if.slave bus
);

    localparam int PW = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(LSU_DEPTH);
    localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

    logic [4:0]    r_mem_rd   [LSU_DEPTH];
    logic [31:0]   r_mem_data [LSU_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_busy;
    logic [4:0]    r_rd_addr;
    logic [31:0]   r_rd_data;
    logic          r_rd_we;

    logic          w_fifo_nempty;
    logic          w_alu_ready;
    logic          w_lsu_ready;
    logic          w_sel_alu;
    logic          w_sel_lsu;
    logic          w_sel_any;
    logic          w_push;
    logic [4:0]    w_sel_rd;
    logic [31:0]   w_sel_data;
    logic [31:0]   w_busy_nxt;

    assign w_fifo_nempty = (r_count != '0);
    assign w_alu_ready   = !(w_fifo_nempty && (r_starve == SMAX_C));
    assign w_lsu_ready   = (r_count < DEPTH_C);
    assign w_sel_alu     = bus.alu_valid && w_alu_ready;
    assign w_sel_lsu     = !w_sel_alu && w_fifo_nempty;
    assign w_sel_any     = w_sel_alu || w_sel_lsu;
    assign w_push        = bus.lsu_valid && w_lsu_ready;
    assign w_sel_rd      = w_sel_alu ? bus.alu_rd   : r_mem_rd[r_rptr];
    assign w_sel_data    = w_sel_alu ? bus.alu_data : r_mem_data[r_rptr];

    assign bus.alu_ready = w_alu_ready;
    assign bus.lsu_ready = w_lsu_ready;
    assign bus.busy      = r_busy;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_we     = r_rd_we;

    // Clear for the retiring rd is applied first so a same-edge issue re-sets it.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_sel_any)
            w_busy_nxt[w_sel_rd] = 1'b0;
        if (bus.issue_valid && (bus.issue_rd != 5'd0))
            w_busy_nxt[bus.issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= bus.lsu_rd;
            r_mem_data[r_wptr] <= bus.lsu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_sel_lsu)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_sel_lsu})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_starve <= '0;
        else if (w_sel_lsu || !w_fifo_nempty)
            r_starve <= '0;
        else if (w_sel_alu && (r_starve != SMAX_C))
            r_starve <= r_starve + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_we   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_busy    <= '0;
        end else begin
            r_rd_we <= w_sel_any && (w_sel_rd != 5'd0);
            if (w_sel_any) begin
                r_rd_addr <= w_sel_rd;
                r_rd_data <= w_sel_data;
            end
            r_busy <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: one task per scenario, inline checks
// against hand-computed expected values.
module tb_writeback_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    writeback_arbiter_if bus ();

    writeback_arbiter #(
        .LSU_DEPTH (2),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = 5'd0;
        bus.alu_data    = 32'h0;
        bus.lsu_valid   = 1'b0;
        bus.lsu_rd      = 5'd0;
        bus.lsu_data    = 32'h0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        #2 rst = 1'b1;
        #2;
        n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL reset rd_we: got %0b want 0", bus.rd_we); end
        n_checks++; if (bus.rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset rd_addr: got %0d want 0", bus.rd_addr); end
        n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL reset rd_data: got %h want 0", bus.rd_data); end
        n_checks++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL reset busy: got %h want 0", bus.busy); end
        step();
        step();
        rst = 1'b0;
        step();
        n_checks++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL reset lsu_ready: got %0b want 1", bus.lsu_ready); end
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset alu_ready: got %0b want 1", bus.alu_ready); end
    endtask

    task automatic test_alu_only();
        drive_idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd1;
        step();
        n_checks++; if (bus.busy !== 32'h2) begin n_fail++; $display("FAIL alu_only busy_set: got %h want 00000002", bus.busy); end
        drive_idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd1;
        bus.alu_data  = 32'hDEADBEEF;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_only alu_ready: got %0b want 1", bus.alu_ready); end
        step();
        n_checks++; if (bus.rd_we !== 1'b1) begin n_fail++; $display("FAIL alu_only rd_we: got %0b want 1", bus.rd_we); end
        n_checks++; if (bus.rd_addr !== 5'd1) begin n_fail++; $display("FAIL alu_only rd_addr: got %0d want 1", bus.rd_addr); end
        n_checks++; if (bus.rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_only rd_data: got %h want deadbeef", bus.rd_data); end
        n_checks++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL alu_only busy_clr: got %h want 0", bus.busy); end
        drive_idle();
        step();
        n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL alu_only one_cycle_we: got %0b want 0", bus.rd_we); end
        n_checks++; if (bus.rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_only hold_data: got %h want deadbeef", bus.rd_data); end
        n_checks++; if (bus.rd_addr !== 5'd1) begin n_fail++; $display("FAIL alu_only hold_addr: got %0d want 1", bus.rd_addr); end
    endtask

    task automatic test_contention();
        drive_idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 32'h00001111;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd2;
        bus.lsu_data  = 32'hCAFEBABE;
        #1;
        n_checks++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL contention lsu_ready: got %0b want 1", bus.lsu_ready); end
        step();
        n_checks++; if (bus.rd_addr !== 5'd3 || bus.rd_data !== 32'h00001111 || bus.rd_we !== 1'b1) begin n_fail++; $display("FAIL contention alu_first: got we=%0b addr=%0d data=%h want we=1 addr=3 data=00001111", bus.rd_we, bus.rd_addr, bus.rd_data); end
        drive_idle();
        step();
        n_checks++; if (bus.rd_addr !== 5'd2 || bus.rd_data !== 32'hCAFEBABE || bus.rd_we !== 1'b1) begin n_fail++; $display("FAIL contention lsu_second: got we=%0b addr=%0d data=%h want we=1 addr=2 data=cafebabe", bus.rd_we, bus.rd_addr, bus.rd_data); end
        step();
        n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL contention drained: got we=%0b want 0", bus.rd_we); end
    endtask

    task automatic test_starvation();
        drive_idle();
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd4;
        bus.lsu_data  = 32'h44444444;
        step();
        drive_idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd6;
        for (int k = 0; k < 4; k++) begin
            bus.alu_data = 32'h100 + 32'(k);
            #1;
            n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL starve alu_ready_%0d: got %0b want 1", k, bus.alu_ready); end
            step();
            n_checks++; if (bus.rd_addr !== 5'd6 || bus.rd_data !== 32'h100 + 32'(k)) begin n_fail++; $display("FAIL starve alu_write_%0d: got addr=%0d data=%h want addr=6 data=%h", k, bus.rd_addr, bus.rd_data, 32'h100 + 32'(k)); end
        end
        bus.alu_data = 32'h104;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL starve forced_block: got alu_ready=%0b want 0", bus.alu_ready); end
        step();
        n_checks++; if (bus.rd_addr !== 5'd4 || bus.rd_data !== 32'h44444444 || bus.rd_we !== 1'b1) begin n_fail++; $display("FAIL starve lsu_forced: got we=%0b addr=%0d data=%h want we=1 addr=4 data=44444444", bus.rd_we, bus.rd_addr, bus.rd_data); end
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL starve ready_back: got %0b want 1", bus.alu_ready); end
        step();
        n_checks++; if (bus.rd_addr !== 5'd6 || bus.rd_data !== 32'h104) begin n_fail++; $display("FAIL starve held_alu: got addr=%0d data=%h want addr=6 data=00000104", bus.rd_addr, bus.rd_data); end
        drive_idle();
        step();
    endtask

    task automatic test_fifo_full();
        drive_idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd8;
        bus.alu_data  = 32'hA0;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd9;
        bus.lsu_data  = 32'h9;
        step();
        bus.alu_data  = 32'hA1;
        bus.lsu_rd    = 5'd10;
        bus.lsu_data  = 32'hA;
        #1;
        n_checks++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL fifo one_entry_ready: got %0b want 1", bus.lsu_ready); end
        step();
        bus.alu_data  = 32'hA2;
        bus.lsu_rd    = 5'd11;
        bus.lsu_data  = 32'hB;
        #1;
        n_checks++; if (bus.lsu_ready !== 1'b0) begin n_fail++; $display("FAIL fifo full_ready: got %0b want 0", bus.lsu_ready); end
        step();
        n_checks++; if (bus.rd_data !== 32'hA2) begin n_fail++; $display("FAIL fifo alu_while_full: got %h want 000000a2", bus.rd_data); end
        drive_idle();
        step();
        n_checks++; if (bus.rd_addr !== 5'd9 || bus.rd_data !== 32'h9) begin n_fail++; $display("FAIL fifo pop_first: got addr=%0d data=%h want addr=9 data=00000009", bus.rd_addr, bus.rd_data); end
        n_checks++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL fifo ready_after_pop: got %0b want 1", bus.lsu_ready); end
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd12;
        bus.lsu_data  = 32'hC;
        step();
        n_checks++; if (bus.rd_addr !== 5'd10 || bus.rd_data !== 32'hA) begin n_fail++; $display("FAIL fifo pop_second: got addr=%0d data=%h want addr=10 data=0000000a", bus.rd_addr, bus.rd_data); end
        drive_idle();
        step();
        n_checks++; if (bus.rd_addr !== 5'd12 || bus.rd_data !== 32'hC || bus.rd_we !== 1'b1) begin n_fail++; $display("FAIL fifo push_pop_same: got we=%0b addr=%0d data=%h want we=1 addr=12 data=0000000c", bus.rd_we, bus.rd_addr, bus.rd_data); end
        step();
        n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL fifo third_rejected: got we=%0b addr=%0d want we=0", bus.rd_we, bus.rd_addr); end
    endtask

    task automatic test_x0();
        drive_idle();
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd0;
        bus.alu_data    = 32'hFFFFFFFF;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        step();
        n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL x0 rd_we: got %0b want 0", bus.rd_we); end
        n_checks++; if (bus.rd_addr !== 5'd0 || bus.rd_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL x0 addr_data: got addr=%0d data=%h want addr=0 data=ffffffff", bus.rd_addr, bus.rd_data); end
        n_checks++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL x0 busy: got %h want 0", bus.busy); end
        drive_idle();
        step();
    endtask

    task automatic test_scoreboard_race();
        drive_idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        step();
        n_checks++; if (bus.busy !== 32'h20) begin n_fail++; $display("FAIL race busy_set: got %h want 00000020", bus.busy); end
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'h55;
        step();
        n_checks++; if (bus.rd_we !== 1'b1 || bus.rd_addr !== 5'd5) begin n_fail++; $display("FAIL race writeback: got we=%0b addr=%0d want we=1 addr=5", bus.rd_we, bus.rd_addr); end
        n_checks++; if (bus.busy !== 32'h20) begin n_fail++; $display("FAIL race set_wins: got %h want 00000020", bus.busy); end
        bus.issue_valid = 1'b0;
        bus.alu_data    = 32'h56;
        step();
        n_checks++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL race clear: got %h want 0", bus.busy); end
        drive_idle();
        step();
    endtask

    task automatic test_async_reset();
        drive_idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.lsu_valid   = 1'b1;
        bus.lsu_rd      = 5'd13;
        bus.lsu_data    = 32'hD;
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd14;
        bus.alu_data    = 32'hE;
        step();
        drive_idle();
        n_checks++; if (bus.rd_we !== 1'b1 || bus.busy !== 32'h80) begin n_fail++; $display("FAIL arst pre_state: got we=%0b busy=%h want we=1 busy=00000080", bus.rd_we, bus.busy); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.rd_we !== 1'b0 || bus.rd_addr !== 5'd0 || bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL arst outputs: got we=%0b addr=%0d data=%h want all 0", bus.rd_we, bus.rd_addr, bus.rd_data); end
        n_checks++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL arst busy: got %h want 0", bus.busy); end
        n_checks++; if (bus.lsu_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL arst readies: got lsu=%0b alu=%0b want 1 1", bus.lsu_ready, bus.alu_ready); end
        step();
        rst = 1'b0;
        step();
        n_checks++; if (bus.rd_we !== 1'b0) begin n_fail++; $display("FAIL arst fifo_flushed: got we=%0b addr=%0d want we=0", bus.rd_we, bus.rd_addr); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alu_only();
        test_contention();
        test_starvation();
        test_fifo_full();
        test_x0();
        test_scoreboard_race();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
